// File: rtl/dft_pkg.sv
// dft_pkg: shared DFT types and default LBIST constants
package dft_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE} lbist_state_t;
  localparam logic [15:0] LFSR_SEED_D = 16'hACE1;
  localparam logic [15:0] LFSR_POLY_D = 16'hB400;
  localparam logic [15:0] MISR_POLY_D = 16'h1021;
endpackage

// File: rtl/lbist_scan_ctrl_if.sv
// lbist_scan_ctrl_if: test-access and scan-chain signals of the LBIST sequencer
//   master: test-access side and scan-chain wrapper (drive start/abort/exp_sig/chain_scan_out)
//   slave:  the sequencer itself
interface lbist_scan_ctrl_if #(parameter int SIG_W = 16);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] exp_sig;
  logic             busy;
  logic             bist_done;
  logic             bist_fail;
  logic [SIG_W-1:0] signature;
  logic             chain_clk_en;
  logic             chain_scan_en;
  logic             chain_scan_in;
  logic             chain_scan_out;
  modport master (output start, abort, exp_sig, chain_scan_out,
                  input busy, bist_done, bist_fail, signature, chain_clk_en, chain_scan_en, chain_scan_in);
  modport slave  (input start, abort, exp_sig, chain_scan_out,
                  output busy, bist_done, bist_fail, signature, chain_clk_en, chain_scan_en, chain_scan_in);
endinterface

// File: rtl/lbist_misr.sv
// lbist_misr: left-shift serial-input signature register
//   clk, rst_n: clock, async active-low reset
//   en: absorb din this cycle; clr: synchronous clear (wins over en)
//   sig: current signature
module lbist_misr #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);
  logic [SIG_W-1:0] r_sig, w_next;
  assign w_next = (r_sig << 1) ^ (r_sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
  assign sig = r_sig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sig <= '0;
    else if (clr) r_sig <= '0;
    else if (en) r_sig <= w_next;
endmodule

// File: rtl/lbist_scan_ctrl.sv
// lbist_scan_ctrl: logic-BIST sequencer driving a scan chain with LFSR patterns into a MISR
//   clk, rst_n: clock, async active-low reset
//   bus: start/abort/exp_sig in, busy/bist_done/bist_fail/signature out,
//        chain_clk_en/chain_scan_en/chain_scan_in out, chain_scan_out in
module lbist_scan_ctrl import dft_pkg::*; #(
  parameter int               CHAIN_LEN    = 4,
  parameter int               NUM_PATTERNS = 8,
  parameter int               SIG_W        = 16,
  parameter logic [SIG_W-1:0] LFSR_SEED    = LFSR_SEED_D,
  parameter logic [SIG_W-1:0] LFSR_POLY    = LFSR_POLY_D,
  parameter logic [SIG_W-1:0] MISR_POLY    = MISR_POLY_D
) (
  input logic               clk,
  input logic               rst_n,
  lbist_scan_ctrl_if.slave  bus
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  lbist_state_t     r_state, w_next;
  logic [BW-1:0]    r_bit_cnt;
  logic [PW-1:0]    r_pat_cnt;
  logic [SIG_W-1:0] r_lfsr, r_exp, w_sig;
  logic             r_done, r_fail;
  logic             w_start, w_last_bit, w_last_pat, w_shift, w_scan;
  // abort beats a simultaneous start
  assign w_start    = bus.start && !bus.abort && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last_bit = r_bit_cnt == BW'(CHAIN_LEN - 1);
  assign w_last_pat = r_pat_cnt == PW'(NUM_PATTERNS - 1);
  assign w_shift    = r_state == S_SHIFT;
  assign w_scan     = w_shift || r_state == S_UNLOAD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = bus.abort ? S_IDLE :
             w_start ? S_SHIFT :
             r_state == S_SHIFT ? (w_last_bit ? S_CAPTURE : S_SHIFT) :
             r_state == S_CAPTURE ? (w_last_pat ? S_UNLOAD : S_SHIFT) :
             r_state == S_UNLOAD ? (w_last_bit ? S_COMPARE : S_UNLOAD) :
             r_state == S_COMPARE ? S_DONE : r_state;
  always_comb begin
    bus.chain_scan_en = w_scan;
    bus.chain_clk_en  = w_scan || r_state == S_CAPTURE;
    bus.chain_scan_in = w_shift && r_lfsr[0];
    bus.busy          = w_scan || r_state == S_CAPTURE || r_state == S_COMPARE;
    bus.bist_done     = r_done;
    bus.bist_fail     = r_fail;
    bus.signature     = w_sig;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_pat_cnt <= '0;
      r_lfsr    <= LFSR_SEED;
      r_exp     <= '0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
    end else if (bus.abort) begin
      r_bit_cnt <= '0;
      r_pat_cnt <= '0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_pat_cnt <= '0;
      r_lfsr    <= LFSR_SEED;
      r_exp     <= bus.exp_sig;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      if (w_scan) r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      if (w_shift) r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
      if (r_state == S_CAPTURE) r_pat_cnt <= r_pat_cnt + 1'b1;
      if (r_state == S_COMPARE) begin
        r_fail <= w_sig != r_exp;
        r_done <= 1'b1;
      end
    end
  // MISR holds on abort so the partial signature stays observable
  lbist_misr #(.SIG_W(SIG_W), .POLY(MISR_POLY)) u_misr (
    .clk(clk), .rst_n(rst_n), .en(w_scan && !bus.abort), .clr(w_start),
    .din(bus.chain_scan_out), .sig(w_sig)
  );
endmodule

// File: doc/lbist_scan_ctrl.md
Name: lbist_scan_ctrl

Overview:
Logic-BIST sequencer that drives the DFT scan chain with LFSR pseudo-random patterns. Per pattern it shifts CHAIN_LEN bits in, issues one capture cycle, and compacts the shifted-out response into a MISR. After NUM_PATTERNS it unloads the chain, compares the signature against an expected value, and reports done/fail. It sits between the test-access controller (start/abort) and the scan-chain wrapper (scan_en/scan_in/scan_out).

Parameters:
CHAIN_LEN, 4, scan-chain length in flops (>=1)
NUM_PATTERNS, 8, patterns applied per run (>=1)
SIG_W, 16, LFSR and MISR width
LFSR_SEED, 16'hACE1, LFSR value loaded on start (nonzero)
LFSR_POLY, 16'hB400, Galois right-shift LFSR taps
MISR_POLY, 16'h1021, left-shift MISR feedback polynomial

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start pulse; accepted only in IDLE or DONE
abort  in  1  synchronous abort to IDLE
exp_sig  in  SIG_W  golden signature; sampled on accepted start
chain_clk_en  out  1  clock-enable for the chain under test
chain_scan_en  out  1  scan-enable to the chain
chain_scan_in  out  1  serial data into the chain
chain_scan_out  in  1  serial data from the chain
busy  out  1  high in SHIFT/CAPTURE/UNLOAD/COMPARE
bist_done  out  1  sticky completion flag
bist_fail  out  1  sticky mismatch flag, valid when bist_done=1
signature  out  SIG_W  current MISR value

Behaviour:
- Reset (async, rst_n=0): state=IDLE; lfsr=LFSR_SEED; misr=0; counters=0; all 1-bit outputs 0; signature=0.
- States: IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE/DONE + start: latch exp_sig, lfsr<=LFSR_SEED, misr<=0, bit_cnt=0, pat_cnt=0, clear bist_done/bist_fail, go to SHIFT on the next edge.
- SHIFT (CHAIN_LEN cycles): chain_clk_en=1, chain_scan_en=1, chain_scan_in=lfsr[0].
  - Each cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0); misr absorbs chain_scan_out.
  - After the last bit go to CAPTURE.
- CAPTURE (1 cycle): chain_clk_en=1, chain_scan_en=0; LFSR and MISR hold; pat_cnt++.
  - If pat_cnt reaches NUM_PATTERNS go to UNLOAD, else go to SHIFT.
- UNLOAD (CHAIN_LEN cycles): chain_clk_en=1, chain_scan_en=1, chain_scan_in=0; LFSR holds; MISR absorbs. Then go to COMPARE.
- MISR update: misr <= (misr<<1) ^ (misr[SIG_W-1] ? MISR_POLY : 0) ^ {0.., chain_scan_out}.
- COMPARE (1 cycle): bist_fail <= (misr != latched exp_sig); bist_done <= 1; go to DONE.
- DONE: hold flags and signature until the next start.
- chain_clk_en=0 in IDLE/COMPARE/DONE, freezing the chain's functional logic. chain_scan_en=0 outside SHIFT/UNLOAD.
- Latency from the start edge to bist_done=1 is NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+2 cycles. Defaults give 46.
- First SHIFT unloads the chain's post-reset content into the MISR; this is intended and is included in the golden signature.
- start while busy: ignored. abort in any state: IDLE next edge, flags cleared, misr held. abort has priority over simultaneous start.
- Reset mid-run: immediate return to reset values; no partial flags.
- Counters: bit_cnt is clog2(CHAIN_LEN+1) bits and pat_cnt is clog2(NUM_PATTERNS+1) bits; neither wraps within a run.

Decomposition:
- Shared package dft_pkg: state enum lbist_state_t, default LFSR_SEED/LFSR_POLY/MISR_POLY constants.
- One sub-module lbist_misr (SIG_W, POLY; en, clr, din, sig), reused by later response compactors. LFSR stays inline.

Test Plan:
- Chain out tied 0, NUM_PATTERNS=1, CHAIN_LEN=4, exp_sig=0, start -> signature=16'h0000, bist_done=1, bist_fail=0, 11 cycles after start.
- Chain out tied 1, NUM_PATTERNS=1, CHAIN_LEN=4, exp_sig=16'h00FF -> MISR 1,3,7,F,1F,3F,7F,FF; bist_fail=0. Rerun with exp_sig=16'h00FE -> bist_fail=1.
- Defaults with chain_scan_in observed -> first four SHIFT bits 1,0,0,0; chain_scan_en low on exactly 8 CAPTURE cycles; bist_done at cycle 46.
- Connect the 4-bit scan register with a reference model -> signature equals model value; flip one chain flop via force -> bist_fail=1.
- abort at cycle 10, then start -> busy drops next cycle, flags 0; rerun gives identical signature.
- rst_n asserted mid-UNLOAD -> all outputs 0 asynchronously; start pulse while busy -> no restart, cycle count unchanged.
